// File: rtl/vga_pattern_gen.sv
// Test-pattern generator placed behind the VGA timing generator.
// Two-stage pipeline: stage 1 registers the sync/valid inputs together with
// the selected pattern colour, stage 2 registers the final RGB and syncs.
// Mode, box position and frame counter only move on the frame tick, which is
// the rising edge of v_pulse_in, so a whole frame renders with one state set.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int BAR_SHIFT  = 7,
  parameter int GRID_SHIFT = 5,
  parameter int BOX_SIZE   = 64,
  parameter int BOX_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_pulse_in,
  input  logic        v_pulse_in,
  input  logic        video_valid_in,
  input  logic [11:0] x_pos,
  input  logic [11:0] y_pos,
  input  logic        mode_next,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic [1:0]  mode
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t WHITE = '{8'hFF, 8'hFF, 8'hFF};
  localparam rgb_t BLACK = '{8'h00, 8'h00, 8'h00};
  localparam rgb_t NAVY  = '{8'h00, 8'h00, 8'h80};

  // One box axis step: returns {forward_dir, position}. Bounces clamp to the
  // edge rather than overshooting, so the box never leaves the active area.
  function automatic logic [12:0] axis_next(input logic [11:0] pos,
                                            input logic fwd, input int lim);
    logic [12:0] p13;
    p13 = {1'b0, pos};
    if (fwd) begin
      if (p13 + 13'(BOX_STEP + BOX_SIZE) >= 13'(lim))
        return {1'b0, 12'(lim - BOX_SIZE)};
      return {1'b1, pos + 12'(BOX_STEP)};
    end
    if (p13 <= 13'(BOX_STEP))
      return {1'b1, 12'd0};
    return {1'b0, pos - 12'(BOX_STEP)};
  endfunction

  logic              v_q;
  logic              tick;
  logic [1:0]        pend;
  logic [7:0]        frame_cnt;
  logic [11:0]       box_x, box_y;
  logic              dir_x, dir_y;
  logic [12:0]       bx_nxt, by_nxt;

  logic [STAGES:1]   vld_pipe, hs_pipe, vs_pipe;
  rgb_t              pat, rgb1, rgb2;
  logic [2:0]        bar;
  logic              on_grid, in_box;

  assign tick   = v_pulse_in & ~v_q;
  assign bx_nxt = axis_next(box_x, dir_x, H_ACTIVE);
  assign by_nxt = axis_next(box_y, dir_y, V_ACTIVE);

  // Frame-level state: pending mode, displayed mode, frame counter, box.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= 1'b1;
      pend      <= 2'd0;
      mode      <= 2'd0;
      frame_cnt <= 8'd0;
      box_x     <= 12'd0;
      box_y     <= 12'd0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
    end else begin
      v_q <= v_pulse_in;
      // A request on the tick cycle lands in pend only; mode takes old pend.
      if (mode_next) pend <= pend + 2'd1;
      if (tick) begin
        mode             <= pend;
        frame_cnt        <= frame_cnt + 8'd1;
        {dir_x, box_x}   <= bx_nxt;
        {dir_y, box_y}   <= by_nxt;
      end
    end
  end

  assign bar     = 3'(x_pos >> BAR_SHIFT);
  assign on_grid = (x_pos[GRID_SHIFT-1:0] == '0) || (y_pos[GRID_SHIFT-1:0] == '0);
  assign in_box  = ({1'b0, x_pos} >= {1'b0, box_x}) &&
                   ({1'b0, x_pos} <  {1'b0, box_x} + 13'(BOX_SIZE)) &&
                   ({1'b0, y_pos} >= {1'b0, box_y}) &&
                   ({1'b0, y_pos} <  {1'b0, box_y} + 13'(BOX_SIZE));

  // Pattern select for the pixel currently on the inputs.
  always_comb begin
    pat = BLACK;
    unique case (mode)
      2'd0: begin
        unique case (bar)
          3'd0: pat = WHITE;
          3'd1: pat = '{8'hFF, 8'hFF, 8'h00};
          3'd2: pat = '{8'h00, 8'hFF, 8'hFF};
          3'd3: pat = '{8'h00, 8'hFF, 8'h00};
          3'd4: pat = '{8'hFF, 8'h00, 8'hFF};
          3'd5: pat = '{8'hFF, 8'h00, 8'h00};
          3'd6: pat = '{8'h00, 8'h00, 8'hFF};
          3'd7: pat = BLACK;
        endcase
      end
      2'd1: pat = on_grid ? WHITE : BLACK;
      2'd2: pat = in_box ? WHITE : NAVY;
      2'd3: pat = '{x_pos[9:2], y_pos[9:2], frame_cnt};
    endcase
  end

  // Two-stage pixel pipeline; syncs idle high, RGB blanked outside de.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      rgb1     <= BLACK;
      rgb2     <= BLACK;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], video_valid_in};
      hs_pipe  <= {hs_pipe[STAGES-1:1], h_pulse_in};
      vs_pipe  <= {vs_pipe[STAGES-1:1], v_pulse_in};
      rgb1     <= pat;
      rgb2     <= vld_pipe[1] ? rgb1 : BLACK;
    end
  end

  assign vga_hs = hs_pipe[STAGES];
  assign vga_vs = vs_pipe[STAGES];
  assign vga_de = vld_pipe[STAGES];
  assign vga_r  = rgb2.r;
  assign vga_g  = rgb2.g;
  assign vga_b  = rgb2.b;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: stimulus pushes expected pixels with
// their issue cycle; a monitor pops one per output cycle with de high.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_pulse_in, v_pulse_in, video_valid_in, mode_next;
  logic [11:0] x_pos, y_pos;
  logic        vga_hs, vga_vs, vga_de;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [1:0]  mode;

  always #5 clk = ~clk;

  vga_pattern_gen dut (
    .clk(clk), .rst(rst), .h_pulse_in(h_pulse_in), .v_pulse_in(v_pulse_in),
    .video_valid_in(video_valid_in), .x_pos(x_pos), .y_pos(y_pos),
    .mode_next(mode_next), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .mode(mode)
  );

  typedef struct {
    logic [23:0] rgb;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t e_cur;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  logic chk_sync = 1'b0;
  logic hs_d1, hs_d2, vs_d1, vs_d2, de_d1, de_d2;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference two-cycle delay of the raw sync/valid inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) {hs_d1, hs_d2, vs_d1, vs_d2, de_d1, de_d2} <= 6'b111100;
    else begin
      hs_d1 <= h_pulse_in;     hs_d2 <= hs_d1;
      vs_d1 <= v_pulse_in;     vs_d2 <= vs_d1;
      de_d1 <= video_valid_in; de_d2 <= de_d1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every de-high output pixel must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (vga_de) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_de: rgb %0h at cycle %0d with no pixel pending",
                   {vga_r, vga_g, vga_b}, cyc);
        end else begin
          e_cur = q.pop_front();
          chk("pix_rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, e_cur.rgb});
          chk("pix_latency", cyc, e_cur.at + 2);
        end
      end else begin
        chk("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);
      end
      if (chk_sync)
        chk("sync_delay", {29'h0, vga_hs, vga_vs, vga_de}, {29'h0, hs_d2, vs_d2, de_d2});
    end
  end

  task automatic step(input logic h, input logic v, input logic de,
                      input logic [11:0] x, input logic [11:0] y,
                      input logic mn, input logic [23:0] e);
    h_pulse_in = h; v_pulse_in = v; video_valid_in = de;
    x_pos = x; y_pos = y; mode_next = mn;
    if (de) q.push_back('{e, cyc});
    @(posedge clk); #1;
  endtask

  task automatic pix(input logic [11:0] x, input logic [11:0] y, input logic [23:0] e);
    step(1'b1, 1'b1, 1'b1, x, y, 1'b0, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
  endtask

  task automatic pulse_mn();
    step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 24'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    h_pulse_in = 1'b1; v_pulse_in = 1'b1; video_valid_in = 1'b0;
    x_pos = '0; y_pos = '0; mode_next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs",   {31'h0, vga_hs}, 32'd1);
    chk("rst_vs",   {31'h0, vga_vs}, 32'd1);
    chk("rst_de",   {31'h0, vga_de}, 32'd0);
    chk("rst_rgb",  {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("rst_mode", {30'h0, mode}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Mode 0 colour bars with varied hs/de to exercise the sync delay.
    chk_sync = 1'b1;
    step(1'b0, 1'b1, 1'b0, 12'd0,    12'd0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b1, 12'd0,    12'd0, 1'b0, 24'hFFFFFF);
    step(1'b1, 1'b1, 1'b1, 12'd130,  12'd0, 1'b0, 24'hFFFF00);
    step(1'b1, 1'b1, 1'b0, 12'd0,    12'd0, 1'b0, 24'h0);
    pix(12'd1023, 12'd0, 24'h000000);
    step(1'b0, 1'b1, 1'b1, 12'd300,  12'd0, 1'b0, 24'h00FFFF);
    pix(12'd400, 12'd0, 24'h00FF00);
    pix(12'd520, 12'd0, 24'hFF00FF);
    step(1'b0, 1'b1, 1'b0, 12'd0,    12'd0, 1'b0, 24'h0);
    pix(12'd700, 12'd0, 24'hFF0000);
    pix(12'd800, 12'd0, 24'h0000FF);
    pix(12'd127, 12'd0, 24'hFFFFFF);
    pix(12'd128, 12'd0, 24'hFFFF00);
    idle(3);

    // Mid-frame mode request only shows after the next v_pulse rising edge.
    step(1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 1'b1, 24'hFFFFFF);
    pix(12'd130, 12'd0, 24'hFFFF00);
    step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
    chk("mode_hold", {30'h0, mode}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
    chk("mode_adv", {30'h0, mode}, 32'd1);
    pix(12'd32, 12'd5,   24'hFFFFFF);
    pix(12'd5,  12'd64,  24'hFFFFFF);
    pix(12'd33, 12'd33,  24'h000000);
    pix(12'd0,  12'd100, 24'hFFFFFF);
    pix(12'd31, 12'd31,  24'h000000);
    idle(3);
    chk_sync = 1'b0;

    // Reset mid-line during active video.
    pix(12'd10, 12'd10, 24'h000000);
    pix(12'd64, 12'd3,  24'hFFFFFF);
    h_pulse_in = 1'b0; video_valid_in = 1'b1;
    #1 rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_hs",   {31'h0, vga_hs}, 32'd1);
    chk("midrst_vs",   {31'h0, vga_vs}, 32'd1);
    chk("midrst_de",   {31'h0, vga_de}, 32'd0);
    chk("midrst_rgb",  {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    chk("midrst_mode", {30'h0, mode}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    h_pulse_in = 1'b1;
    rst = 1'b0;
    pix(12'd0,   12'd1, 24'hFFFFFF);
    pix(12'd130, 12'd1, 24'hFFFF00);
    idle(3);

    // mode_next held three cycles starting on the tick cycle.
    pulse_mn();                                    // pending 1
    step(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 24'h0); // tick: mode<=1
    step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 24'h0);
    step(1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 24'h0); // pending 0
    chk("coinc_mode", {30'h0, mode}, 32'd1);
    pix(12'd33, 12'd32, 24'hFFFFFF);
    pix(12'd33, 12'd33, 24'h000000);
    tick();
    chk("coinc_next", {30'h0, mode}, 32'd0);
    pix(12'd130, 12'd0, 24'hFFFF00);
    idle(3);

    // Bouncing box: 240 ticks puts box at (960,448) just after the x flip.
    do_reset();
    pulse_mn(); pulse_mn();
    repeat (240) tick();
    chk("box_mode", {30'h0, mode}, 32'd2);
    pix(12'd960,  12'd448, 24'hFFFFFF);
    pix(12'd959,  12'd448, 24'h000080);
    pix(12'd1023, 12'd511, 24'hFFFFFF);
    pix(12'd960,  12'd512, 24'h000080);
    pix(12'd960,  12'd447, 24'h000080);
    tick();                                        // box now (956,444)
    pix(12'd956,  12'd444, 24'hFFFFFF);
    pix(12'd1019, 12'd507, 24'hFFFFFF);
    pix(12'd1020, 12'd444, 24'h000080);
    pix(12'd955,  12'd444, 24'h000080);
    pix(12'd956,  12'd443, 24'h000080);
    idle(3);

    // Gradient: frame_cnt is 242 after the next tick, then wraps at 256.
    pulse_mn();
    tick();
    chk("grad_mode", {30'h0, mode}, 32'd3);
    pix(12'd1020, 12'd4,    24'hFF01F2);
    pix(12'd0,    12'd1023, 24'h00FFF2);
    pix(12'd7,    12'd8,    24'h0102F2);
    repeat (13) tick();
    pix(12'd1020, 12'd4,    24'hFF01FF);
    tick();
    pix(12'd1020, 12'd4,    24'hFF0100);
    idle(4);

    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Downstream of the VGA sync/timing generator. Consumes its sync pulses, video-valid flag and active-area x/y position, and produces 24-bit RGB pixel data.
- Delays the sync pulses and data-enable so they stay aligned with the RGB output.
- Provides four selectable test patterns: colour bars, grid, bouncing box and gradient.
- Pattern changes take effect only at frame boundaries.

Parameters:
- H_ACTIVE, 1024, active pixels per line (box bounce bound).
- V_ACTIVE, 768, active lines per frame (box bounce bound).
- BAR_SHIFT, 7, colour-bar index = x_pos >> BAR_SHIFT (bits [2:0] used).
- GRID_SHIFT, 5, grid pitch = 2^GRID_SHIFT pixels.
- BOX_SIZE, 64, bouncing box edge length in pixels.
- BOX_STEP, 4, box displacement per frame on each axis.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- h_pulse_in  in  1  horizontal sync from timing generator, active-low
- v_pulse_in  in  1  vertical sync from timing generator, active-low
- video_valid_in  in  1  active-area flag
- x_pos  in  12  active-area column
- y_pos  in  12  active-area row
- mode_next  in  1  single-cycle request to advance the pattern mode
- vga_hs  out  1  horizontal sync, delayed 2 cycles
- vga_vs  out  1  vertical sync, delayed 2 cycles
- vga_de  out  1  data enable, delayed 2 cycles
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- mode  out  2  currently displayed mode

Behaviour:
- Reset (async, active-high) values:
  - vga_hs=1, vga_vs=1, vga_de=0, RGB=0.
  - mode=0, pending mode=0, frame_cnt=0.
  - box_x=0, box_y=0, direction right/down.
  - All pipeline registers cleared; sync pipeline registers cleared to 1.
  - Reset mid-frame takes effect immediately. Output resumes at the next pixel after release, with 2-cycle latency.
- Latency:
  - Exactly 2 clocks from inputs to all outputs.
  - Stage 1 registers the inputs plus the pattern-select/compare results.
  - Stage 2 registers the final RGB, hs, vs and de.
- De-assertion: RGB is forced to 0 whenever the stage-2 de is 0.
- Frame tick:
  - A one-cycle internal pulse on the rising edge of v_pulse_in (sync end), detected with a registered copy of v_pulse_in.
  - The registered copy resets to 1, so no tick is produced on release from reset.
- On each frame tick:
  - frame_cnt (8-bit) increments and wraps 255→0.
  - mode ← pending mode.
  - The box position updates.
- mode_next:
  - Each high cycle increments the pending mode modulo 4 (3→0).
  - If mode_next coincides with a frame tick, the tick loads the old pending value. The increment lands in pending only and is displayed at the next tick.
- Mode 0, colour bars, selected by bar index 0..7: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Mode 1, grid: white when x_pos[GRID_SHIFT-1:0]==0 or y_pos[GRID_SHIFT-1:0]==0; black otherwise.
- Mode 2, box: white when box_x ≤ x_pos < box_x+BOX_SIZE and box_y ≤ y_pos < box_y+BOX_SIZE; 000080 navy otherwise. All compares are unsigned 13-bit, so no overflow.
- Mode 3, gradient: r=x_pos[9:2], g=y_pos[9:2], b=frame_cnt.
- Box motion, X axis (Y is identical with V_ACTIVE):
  - Moving right: if box_x+BOX_STEP+BOX_SIZE ≥ H_ACTIVE, then box_x ← H_ACTIVE−BOX_SIZE and the direction flips to left. Otherwise box_x += BOX_STEP.
  - Moving left: if box_x ≤ BOX_STEP, then box_x ← 0 and the direction flips to right. Otherwise box_x −= BOX_STEP.
  - Positions are never outside [0, H_ACTIVE−BOX_SIZE].
- Frame-boundary rules:
  - Box position and mode never change mid-frame.
  - The pixel stream between two ticks uses one consistent mode/box/frame_cnt set.

Test Plan:
- Reset, then drive 1024x768 timing with mode 0 → vga_de/hs/vs equal the inputs delayed exactly 2 clocks. Pixel x=0 → FFFFFF; x=130 → FFFF00; x=1023 → 000000.
- Pulse mode_next once mid-frame → mode stays 0 until the next v_pulse_in rising edge, then mode=1. In mode 1, pixels (32,5) and (5,64) → FFFFFF; pixel (33,33) → 000000.
- Mode 2, run 241 frames from reset → box_x reaches 960 and the direction flips. The next frame gives box_x=956. Pixel (960,y in box) → FFFFFF; pixel (959,·) → 000080.
- Mode 3, run 256 frames → frame_cnt wraps to 0 and vga_b returns to 00. Pixel x=1020,y=4 → r=FF, g=01.
- Assert rst mid-line during active video → outputs go immediately to hs=1, vs=1, de=0, RGB=0, mode=0. After release, the first valid pixel appears 2 clocks after video_valid_in.
- mode_next held high for 3 cycles coincident with a frame tick → displayed mode takes the old pending value. The next tick shows old+3 mod 4.
